kernel_pr_update_coalescer: RTL and testbench
=============================================

// Module: kernel_pr_update_coalescer
// PURPOSE
//   Downstream consumer of the 64-bit PR update FIFO (depth-3 shift-register FIFO).
//   Pops {vid[63:32], contrib[31:0]} tuples and merges runs of consecutive tuples with equal vid
//   by adding contrib (32-bit unsigned fixed point).
//   Pushes coalesced tuples into the next ap_fifo-style FIFO toward the rank-memory writer.
//   Cuts write traffic for sorted/clustered edge streams. Tuple order is preserved.
// PARAMETERS
//   DATA_WIDTH     64            tuple width; fixed split: vid = [63:32], contrib = [31:0]
//   MAX_MERGE      16            max tuples merged into one output; range 1..65535; 1 = pass-through
//   FLUSH_TIMEOUT  32            idle cycles before a held tuple is flushed; 0 = never flush on idle
//   EOS_VID        32'hFFFFFFFF  vid value that marks end-of-stream; never merged, always forwarded
// PORTS
//   clk         in   1   clock, all logic rising-edge
//   reset       in   1   synchronous, active-high reset
//   in_empty_n  in   1   upstream FIFO has data
//   in_read     out  1   pop strobe; combinational
//   in_dout     in   64  upstream FIFO head word, valid while in_empty_n=1
//   out_full_n  in   1   downstream FIFO has space
//   out_write   out  1   push strobe = out_vld & out_full_n
//   out_din     out  64  output register contents
// BEHAVIOUR
//   Storage: hold register {hold_vid, hold_val, merge_cnt}; output register {out_vld, out_din}; idle_cnt.
//   Output slot free in a cycle iff !out_vld | out_full_n. A slot being drained can be reloaded that edge.
//   Stall = out_vld & !out_full_n.
//   in_read = in_empty_n & !stall & state!=EOS_PEND & !reset. Accept = in_empty_n & in_read.
//   FSM states: IDLE (hold empty), ACC (hold valid), EOS_PEND (hold pushed, marker waiting).
//   IDLE, accept non-EOS tuple -> hold <= tuple, merge_cnt <= 1, -> ACC.
//   IDLE, accept EOS tuple -> out <= EOS tuple, stay IDLE.
//   ACC, accept tuple with vid==hold_vid and merge_cnt<MAX_MERGE ->
//     hold_val <= hold_val+contrib, merge_cnt++.
//   ACC, accept tuple with vid!=hold_vid, or merge_cnt==MAX_MERGE ->
//     out <= hold, hold <= tuple, merge_cnt <= 1.
//   ACC, accept EOS tuple -> out <= hold, latch the marker, -> EOS_PEND.
//   EOS_PEND, slot free -> out <= marker, -> IDLE. Input is not read while in EOS_PEND.
//   Idle flush: idle_cnt clears on accept and increments on each non-accept ACC cycle.
//     When idle_cnt==FLUSH_TIMEOUT (nonzero) and the slot is free -> out <= hold, -> IDLE.
//   Latency: tuple accepted in cycle c and flushed by a tuple accepted in cycle c+1 ->
//     out_write in cycle c+2 (slot free).
//   Timeout path, no further input: out_write in cycle c+FLUSH_TIMEOUT+2.
//   Adder: 32-bit, wraps mod 2^32 (see CONFIGURATION). Carry is discarded; vid is never modified.
//   Simultaneous load and drain of the output register is legal. No bubble at full throughput:
//     1 tuple/cycle in, 1 tuple/cycle out.
//   Reset (any cycle, including mid-merge or EOS_PEND):
//     next cycle state=IDLE, out_vld=0, out_din=0, idle_cnt=0, merge_cnt=0.
//     Held or partially merged data is discarded.
//     During reset: in_read=0, out_write=0.
//   in_dout is sampled only on accept. out_din is held stable while out_vld & !out_full_n.
// CONFIGURATION
//   PR_COALESCE_SAT_EN defined:
//     contrib add saturates at 32'hFFFFFFFF; a sticky flag sets on saturation
//     and clears on the next load into the hold register.
//   PR_COALESCE_SAT_EN undefined: add wraps modulo 2^32. No extra logic.
// TESTING
//   1. In (5,10),(5,20),(5,3),EOS back-to-back, out_full_n=1 -> out (5,33) then EOS; exactly 2 writes.
//   2. In (1,1),(2,2),(1,4),EOS -> out (1,1),(2,2),(1,4),EOS in order.
//      Non-adjacent equal vids are not merged.
//   3. MAX_MERGE=4, six tuples (7,1) then EOS -> out (7,4),(7,2),EOS.
//   4. Random stream with out_full_n low for 10 cycles mid-stream ->
//      in_read=0 while stalled; out_din stable; output sums match the reference model; no loss or duplicate.
//   5. (9,32'hFFFFFFF0)+(9,32'h20) -> out (9,32'h00000010) without the macro;
//      (9,32'hFFFFFFFF) with PR_COALESCE_SAT_EN.
//   6. FLUSH_TIMEOUT=8: (3,5) accepted in cycle 0, then in_empty_n=0 -> out_write with (3,5) in cycle 10.
//      Reset asserted in cycle 5 of a repeat run -> no output at all.

Source files
------------

// File: rtl/kernel_pr_update_coalescer.sv
// PR update coalescer: merges runs of equal-vid {vid, contrib} tuples between two ap_fifo-style FIFOs.
// Optional macro PR_COALESCE_SAT_EN: saturating contrib add with a sticky saturation flag.
module kernel_pr_update_coalescer #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned MAX_MERGE     = 16,
  parameter int unsigned FLUSH_TIMEOUT = 32,
  parameter logic [31:0] EOS_VID       = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_empty_n,
  output logic                  in_read,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  out_full_n,
  output logic                  out_write,
  output logic [DATA_WIDTH-1:0] out_din
);

  localparam int unsigned IW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACC, EOS_PEND} state_t;

  state_t          state, state_n;
  logic [31:0]     hold_vid, hold_vid_n, hold_val, hold_val_n, merged;
  logic [15:0]     merge_cnt, merge_cnt_n;
  logic [IW-1:0]   idle_cnt, idle_cnt_n;
  logic            out_vld, out_vld_n;
  logic [DATA_WIDTH-1:0] out_din_n;
  logic [31:0]     in_vid, in_contrib;
  logic            stall, slot_free, accept, in_eos, same_vid, timed_out;

  assign in_vid     = in_dout[63:32];
  assign in_contrib = in_dout[31:0];
  assign stall      = out_vld & ~out_full_n;
  assign slot_free  = ~stall;
  assign in_read    = in_empty_n & ~stall & (state != EOS_PEND) & ~reset;
  assign accept     = in_empty_n & in_read;
  assign out_write  = out_vld & out_full_n & ~reset;
  assign in_eos     = (in_vid == EOS_VID);
  assign same_vid   = (in_vid == hold_vid) && (merge_cnt < 16'(MAX_MERGE));
  assign timed_out  = (FLUSH_TIMEOUT != 0) && (idle_cnt == IW'(FLUSH_TIMEOUT));

`ifdef PR_COALESCE_SAT_EN
  logic [32:0] sum_wide;
  logic        sat_flag;
  logic        sat_hit, hold_load;

  assign sum_wide  = {1'b0, hold_val} + {1'b0, in_contrib};
  assign merged    = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
  assign sat_hit   = accept & (state == ACC) & ~in_eos & same_vid & sum_wide[32];
  assign hold_load = accept & (((state == IDLE) & ~in_eos) |
                               ((state == ACC) & (in_eos | ~same_vid)));

  always_ff @(posedge clk) begin
    if (reset)          sat_flag <= 1'b0;
    else if (hold_load) sat_flag <= 1'b0;
    else if (sat_hit)   sat_flag <= 1'b1;
  end
`else
  assign merged = hold_val + in_contrib;
`endif

  // Accepts only happen when the output slot is free, so every load below has room.
  always_comb begin
    state_n     = state;
    hold_vid_n  = hold_vid;
    hold_val_n  = hold_val;
    merge_cnt_n = merge_cnt;
    idle_cnt_n  = idle_cnt;
    out_vld_n   = stall;
    out_din_n   = out_din;
    unique case (state)
      IDLE: begin
        idle_cnt_n = '0;
        if (accept) begin
          if (in_eos) begin
            out_vld_n = 1'b1;
            out_din_n = in_dout;
          end else begin
            hold_vid_n  = in_vid;
            hold_val_n  = in_contrib;
            merge_cnt_n = 16'd1;
            state_n     = ACC;
          end
        end
      end
      ACC: begin
        if (accept) begin
          idle_cnt_n = '0;
          if (in_eos) begin
            out_vld_n   = 1'b1;
            out_din_n   = {hold_vid, hold_val};
            hold_vid_n  = in_vid;
            hold_val_n  = in_contrib;
            merge_cnt_n = '0;
            state_n     = EOS_PEND;
          end else if (same_vid) begin
            hold_val_n  = merged;
            merge_cnt_n = merge_cnt + 16'd1;
          end else begin
            out_vld_n   = 1'b1;
            out_din_n   = {hold_vid, hold_val};
            hold_vid_n  = in_vid;
            hold_val_n  = in_contrib;
            merge_cnt_n = 16'd1;
          end
        end else if (timed_out) begin
          if (slot_free) begin
            out_vld_n   = 1'b1;
            out_din_n   = {hold_vid, hold_val};
            merge_cnt_n = '0;
            idle_cnt_n  = '0;
            state_n     = IDLE;
          end
        end else begin
          idle_cnt_n = idle_cnt + IW'(1);
        end
      end
      EOS_PEND: begin
        if (slot_free) begin
          out_vld_n = 1'b1;
          out_din_n = {hold_vid, hold_val};
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_vid  <= '0;
      hold_val  <= '0;
      merge_cnt <= '0;
      idle_cnt  <= '0;
      out_vld   <= 1'b0;
      out_din   <= '0;
    end else begin
      state     <= state_n;
      hold_vid  <= hold_vid_n;
      hold_val  <= hold_val_n;
      merge_cnt <= merge_cnt_n;
      idle_cnt  <= idle_cnt_n;
      out_vld   <= out_vld_n;
      out_din   <= out_din_n;
    end
  end

endmodule

// File: tb/tb_kernel_pr_update_coalescer.sv
// Self-checking bench for kernel_pr_update_coalescer (MAX_MERGE=4, FLUSH_TIMEOUT=8).
// Directed streams plus a random stream with a mid-stream output stall, checked against a grouping model.
module tb_kernel_pr_update_coalescer;

  localparam int MAXM = 4;
  localparam int TMO  = 8;
  localparam logic [31:0] EOS = 32'hFFFF_FFFF;

  typedef logic [63:0] q_t[$];

  logic        clk, reset, in_empty_n, in_read, out_full_n, out_write;
  logic [63:0] in_dout, out_din;

  int n_chk = 0;
  int n_bad = 0;
  q_t stim_q, acc_q, obs_q;

  kernel_pr_update_coalescer #(
    .DATA_WIDTH(64), .MAX_MERGE(MAXM), .FLUSH_TIMEOUT(TMO), .EOS_VID(EOS)
  ) dut (
    .clk(clk), .reset(reset), .in_empty_n(in_empty_n), .in_read(in_read),
    .in_dout(in_dout), .out_full_n(out_full_n), .out_write(out_write), .out_din(out_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (out_write === 1'b1) obs_q.push_back(out_din);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected output: consecutive equal vids grouped into chunks of at most MAXM, EOS passed through.
  function automatic q_t model(q_t a);
    q_t r;
    bit open = 0;
    logic [31:0] v = '0;
    logic [32:0] s = '0;
    int n = 0;
    foreach (a[i]) begin
      if (a[i][63:32] == EOS) begin
        if (open) r.push_back({v, s[31:0]});
        open = 0;
        r.push_back(a[i]);
      end else if (open && a[i][63:32] == v && n < MAXM) begin
        s = {1'b0, s[31:0]} + {1'b0, a[i][31:0]};
`ifdef PR_COALESCE_SAT_EN
        if (s > 33'h0_FFFF_FFFF) s = 33'h0_FFFF_FFFF;
`endif
        n++;
      end else begin
        if (open) r.push_back({v, s[31:0]});
        open = 1;
        v = a[i][63:32];
        s = {1'b0, a[i][31:0]};
        n = 1;
      end
    end
    if (open) r.push_back({v, s[31:0]});
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_empty_n = 1'b0; out_full_n = 1'b1; in_dout = '0;
    repeat (2) begin @(posedge clk); #2; end
    reset = 1'b0;
    obs_q.delete(); acc_q.delete();
  endtask

  // Presents stim_q; gap_pct = chance of an empty cycle; stall_at >= 0 holds out_full_n low 10 cycles.
  task automatic feed(input int gap_pct, input int stall_at);
    int cyc = 0, idx = 0, empties = 0;
    bit stalled;
    q_t e;
    while (idx < stim_q.size() && cyc < 5000) begin
      in_dout = stim_q[idx];
      stalled = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 10);
      out_full_n = ~stalled;
      if (stalled || (stall_at >= 0 && cyc == stall_at + 10) || empties >= 4 ||
          $urandom_range(99) >= gap_pct) begin
        in_empty_n = 1'b1; empties = 0;
      end else begin
        in_empty_n = 1'b0; empties++;
      end
      @(negedge clk);
      if (stalled && cyc >= stall_at + 6) begin
        e = model(acc_q);
        check("stall_in_read", in_read, 1'b0);
        check("stall_out_din", out_din, (obs_q.size() < e.size()) ? e[obs_q.size()] : 64'hBAD);
      end
      if (in_read && in_empty_n) begin
        acc_q.push_back(stim_q[idx]);
        idx++;
      end
      @(posedge clk); #2;
      cyc++;
    end
    in_empty_n = 1'b0; out_full_n = 1'b1;
    if (cyc >= 5000) check("feed_budget", idx, stim_q.size());
  endtask

  task automatic expect_out(input string tag, input q_t exp);
    int k = 0;
    while (obs_q.size() < exp.size() && k < 300) begin @(posedge clk); #2; k++; end
    repeat (5) begin @(posedge clk); #2; end
    check({tag, "_count"}, obs_q.size(), exp.size());
    foreach (exp[i]) check({tag, "_data"}, (i < obs_q.size()) ? obs_q[i] : 64'hX, exp[i]);
  endtask

  task automatic run_directed(input string tag, input q_t stim, input q_t exp);
    do_reset();
    stim_q = stim;
    feed(0, -1);
    expect_out(tag, exp);
  endtask

  task automatic timeout_run(input bit rst_mid);
    int first = -1;
    do_reset();
    in_dout = {32'd3, 32'd5};
    in_empty_n = 1'b1;
    @(negedge clk);
    check("tmo_accept", in_read, 1'b1);
    @(posedge clk); #2;
    in_empty_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      reset = rst_mid && (k == 5);
      @(negedge clk);
      if (reset) check("tmo_rst_write", out_write, 1'b0);
      if (out_write && first < 0) first = k;
      @(posedge clk); #2;
    end
    reset = 1'b0;
    if (rst_mid) begin
      check("tmo_rst_count", obs_q.size(), 0);
    end else begin
      check("tmo_cycle", first, 10);
      check("tmo_count", obs_q.size(), 1);
      check("tmo_data", (obs_q.size() > 0) ? obs_q[0] : 64'hX, {32'd3, 32'd5});
    end
  endtask

  initial begin
    q_t s, e;
    logic [31:0] v;

    reset = 1'b1; in_empty_n = 1'b1; out_full_n = 1'b1; in_dout = {32'd5, 32'd1};
    @(posedge clk); #2;
    @(negedge clk);
    check("rst_in_read", in_read, 1'b0);
    check("rst_out_write", out_write, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0; in_empty_n = 1'b0;
    @(negedge clk);
    check("rst_out_din", out_din, 64'h0);
    check("rst_out_write_after", out_write, 1'b0);
    @(posedge clk); #2;

    s = '{{32'd5, 32'd10}, {32'd5, 32'd20}, {32'd5, 32'd3}, {EOS, 32'd0}};
    e = '{{32'd5, 32'd33}, {EOS, 32'd0}};
    run_directed("merge3", s, e);

    s = '{{32'd1, 32'd1}, {32'd2, 32'd2}, {32'd1, 32'd4}, {EOS, 32'd7}};
    e = '{{32'd1, 32'd1}, {32'd2, 32'd2}, {32'd1, 32'd4}, {EOS, 32'd7}};
    run_directed("nonadj", s, e);

    s = '{{32'd7, 32'd1}, {32'd7, 32'd1}, {32'd7, 32'd1}, {32'd7, 32'd1},
          {32'd7, 32'd1}, {32'd7, 32'd1}, {EOS, 32'd0}};
    e = '{{32'd7, 32'd4}, {32'd7, 32'd2}, {EOS, 32'd0}};
    run_directed("maxmerge", s, e);

    s = '{{32'd9, 32'hFFFF_FFF0}, {32'd9, 32'h20}, {EOS, 32'd0}};
`ifdef PR_COALESCE_SAT_EN
    e = '{{32'd9, 32'hFFFF_FFFF}, {EOS, 32'd0}};
`else
    e = '{{32'd9, 32'h0000_0010}, {EOS, 32'd0}};
`endif
    run_directed("wrap", s, e);

    s = '{{EOS, 32'd1}, {32'd4, 32'd2}, {EOS, 32'd3}, {EOS, 32'd4}};
    e = '{{EOS, 32'd1}, {32'd4, 32'd2}, {EOS, 32'd3}, {EOS, 32'd4}};
    run_directed("eos_only", s, e);

    for (int r = 0; r < 2; r++) begin
      do_reset();
      stim_q.delete();
      v = 32'd1;
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(99) < 40) v = $urandom_range(5);
        stim_q.push_back({v, (r == 0) ? 32'($urandom_range(1000)) : 32'($urandom)});
      end
      stim_q.push_back({EOS, 32'($urandom)});
      feed(30, 20);
      check("rand_accepted", acc_q.size(), stim_q.size());
      expect_out("rand", model(acc_q));
    end

    timeout_run(1'b0);
    timeout_run(1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
